// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 18-bit ALU datapath: accepts one instruction,
// decodes it, steps it through EXEC and writes the result back via a granted port.
module alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [17:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [3:0]       rf_raddr1,
  output logic [3:0]       rf_raddr2,
  output logic [5:0]       alu_imm,
  output logic             alu_mux1_select,
  output logic [1:0]       alu_mux2_select,
  input  logic [17:0]      alu_result,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [17:0]      rf_wdata,
  input  logic             wb_grant,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] illegal_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [17:0] ir;

  logic [3:0]  ir_op;
  logic [3:0]  ir_dst;
  logic [3:0]  ir_s1;
  logic [3:0]  ir_s2;
  logic [5:0]  ir_imm;

  logic        dec_legal;
  logic        dec_imm_form;
  logic [1:0]  dec_mux2;

  assign ir_op  = ir[17:14];
  assign ir_dst = ir[13:10];
  assign ir_s1  = ir[9:6];
  assign ir_s2  = ir[5:2];
  assign ir_imm = ir[5:0];

  // Opcode decode works only on the latched IR, never on the live instr bus.
  always_comb begin
    dec_legal    = 1'b1;
    dec_imm_form = 1'b0;
    dec_mux2     = 2'b00;
    case (ir_op)
      4'b0000: begin
        dec_mux2 = 2'b00;
      end
      4'b0001: begin
        dec_mux2     = 2'b00;
        dec_imm_form = 1'b1;
      end
      4'b0010: begin
        dec_mux2 = 2'b01;
      end
      4'b0011: begin
        dec_mux2     = 2'b01;
        dec_imm_form = 1'b1;
      end
      4'b0100: begin
        dec_mux2 = 2'b10;
      end
      4'b0101: begin
        dec_mux2 = 2'b11;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Handshake: a transfer happens on a rising edge where instr_valid and
  // instr_ready are both 1. instr_ready is a registered flag that is high only
  // in IDLE and never looks at instr_valid; instr is ignored in other states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      ir              <= '0;
      instr_ready     <= 1'b0;
      rf_raddr1       <= '0;
      rf_raddr2       <= '0;
      alu_imm         <= '0;
      alu_mux1_select <= 1'b0;
      alu_mux2_select <= 2'b00;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      retired_count   <= '0;
      illegal_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          if (dec_legal) begin
            rf_raddr1       <= ir_s1;
            rf_raddr2       <= dec_imm_form ? 4'd0 : ir_s2;
            alu_imm         <= dec_imm_form ? ir_imm : 6'd0;
            alu_mux1_select <= dec_imm_form;
            alu_mux2_select <= dec_mux2;
            rf_waddr        <= ir_dst;
            state           <= S_EXEC;
          end else begin
            illegal_count <= illegal_count + CNT_ONE;
            instr_ready   <= 1'b1;
            state         <= S_IDLE;
          end
        end
        S_EXEC: begin
          rf_wdata <= alu_result;
          rf_we    <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          // Address and data stay frozen until the write port is granted.
          if (wb_grant) begin
            rf_we         <= 1'b0;
            retired_count <= retired_count + CNT_ONE;
            instr_ready   <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign done      = rf_we && wb_grant && !rst;
  assign illegal   = (state == S_DECODE) && !dec_legal && !rst;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a vector table with hand-computed results plus
// hand-written sequences for write-back stall, mid-flight reset, held valid and counter wrap.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] instr;
  logic        instr_valid;
  logic [17:0] alu_result;
  logic        wb_grant;

  logic        instr_ready;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [5:0]  alu_imm;
  logic        alu_mux1_select;
  logic [1:0]  alu_mux2_select;
  logic        rf_we, done, illegal;
  logic [17:0] rf_wdata;
  logic [15:0] retired_count, illegal_count;
  logic [1:0]  dbg_state;

  logic        w_instr_ready;
  logic [3:0]  w_rf_raddr1, w_rf_raddr2, w_rf_waddr;
  logic [5:0]  w_alu_imm;
  logic        w_alu_mux1_select;
  logic [1:0]  w_alu_mux2_select;
  logic        w_rf_we, w_done, w_illegal;
  logic [17:0] w_rf_wdata;
  logic [2:0]  w_retired_count, w_illegal_count;
  logic [1:0]  w_dbg_state;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .alu_imm(alu_imm), .alu_mux1_select(alu_mux1_select),
    .alu_mux2_select(alu_mux2_select), .alu_result(alu_result), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_grant(wb_grant), .done(done),
    .illegal(illegal), .retired_count(retired_count),
    .illegal_count(illegal_count), .dbg_state(dbg_state)
  );

  // Narrow-counter copy driven by the same stimulus, used to reach counter wrap quickly.
  alu_sequencer #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(w_instr_ready), .rf_raddr1(w_rf_raddr1), .rf_raddr2(w_rf_raddr2),
    .alu_imm(w_alu_imm), .alu_mux1_select(w_alu_mux1_select),
    .alu_mux2_select(w_alu_mux2_select), .alu_result(alu_result), .rf_we(w_rf_we),
    .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata), .wb_grant(wb_grant), .done(w_done),
    .illegal(w_illegal), .retired_count(w_retired_count),
    .illegal_count(w_illegal_count), .dbg_state(w_dbg_state)
  );

  // Datapath model: fixed register file contents and the four ALU functions.
  logic [17:0] rf_model [16];
  logic [17:0] src1, src2;
  logic        alu_corrupt;

  always_comb begin
    src1 = rf_model[rf_raddr1];
    src2 = alu_mux1_select ? {{12{alu_imm[5]}}, alu_imm} : rf_model[rf_raddr2];
    case (alu_mux2_select)
      2'b00:   alu_result = src1 + src2;
      2'b01:   alu_result = src1 & src2;
      2'b10:   alu_result = ~(src1 & src2);
      default: alu_result = ~(src1 | src2);
    endcase
    if (alu_corrupt) alu_result = 18'h2AAAA;
  end

  typedef struct {
    logic [17:0] instr;
    logic        legal;
    logic [3:0]  raddr1;
    logic [3:0]  raddr2;
    logic [5:0]  imm;
    logic        mux1;
    logic [1:0]  mux2;
    logic [3:0]  waddr;
    logic [17:0] wdata;
  } vec_t;

  vec_t vecs [9];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ret  = 0;
  int exp_ill  = 0;
  int commits  = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (rf_we && wb_grant && !rst) commits++;
    if (instr_valid && instr_ready) acc_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_counts();
    check("retired_count", 32'(retired_count), 32'(exp_ret % 65536));
    check("illegal_count", 32'(illegal_count), 32'(exp_ill % 65536));
    check("w_retired_count", 32'(w_retired_count), 32'(exp_ret % 8));
    check("w_illegal_count", 32'(w_illegal_count), 32'(exp_ill % 8));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) return;
      @(negedge clk);
    end
    check("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  // Called just after a falling edge; returns just after the falling edge in which
  // the sequencer is back in IDLE with instr_ready high.
  task automatic run_vec(input vec_t v);
    wait_ready();
    instr       = v.instr;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 18'h3FFFF;
    check("decode_state", 32'(dbg_state), 32'd1);
    check("decode_ready", 32'(instr_ready), 32'd0);
    check("illegal_pulse", 32'(illegal), 32'(!v.legal));
    if (!v.legal) begin
      exp_ill++;
      @(negedge clk);
      check("illegal_ready", 32'(instr_ready), 32'd1);
      check("illegal_clear", 32'(illegal), 32'd0);
      check("illegal_no_we", 32'(rf_we), 32'd0);
      check_counts();
    end else begin
      @(negedge clk);
      check("exec_state", 32'(dbg_state), 32'd2);
      check("exec_raddr1", 32'(rf_raddr1), 32'(v.raddr1));
      check("exec_raddr2", 32'(rf_raddr2), 32'(v.raddr2));
      check("exec_imm", 32'(alu_imm), 32'(v.imm));
      check("exec_mux1", 32'(alu_mux1_select), 32'(v.mux1));
      check("exec_mux2", 32'(alu_mux2_select), 32'(v.mux2));
      check("exec_no_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      check("wb_we", 32'(rf_we), 32'd1);
      check("wb_waddr", 32'(rf_waddr), 32'(v.waddr));
      check("wb_wdata", 32'(rf_wdata), 32'(v.wdata));
      check("wb_done", 32'(done), 32'd1);
      exp_ret++;
      @(negedge clk);
      check("idle_ready", 32'(instr_ready), 32'd1);
      check("idle_done", 32'(done), 32'd0);
      check("idle_we", 32'(rf_we), 32'd0);
      check("idle_hold_wdata", 32'(rf_wdata), 32'(v.wdata));
      check_counts();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 16; i++) rf_model[i] = 18'h0;
    rf_model[1] = 18'd5;
    rf_model[2] = 18'd7;
    rf_model[5] = 18'h0F0F0;
    rf_model[6] = 18'h00FF0;

    //          instr     legal ra1   ra2   imm    mux1  mux2   wa    wdata
    vecs[0] = '{18'h00C48, 1'b1, 4'd1, 4'd2, 6'h00, 1'b0, 2'b00, 4'd3, 18'd12};    // ADD r3=r1+r2
    vecs[1] = '{18'h0507F, 1'b1, 4'd1, 4'd0, 6'h3F, 1'b1, 2'b00, 4'd4, 18'd4};     // ADDI r4=r1-1
    vecs[2] = '{18'h09558, 1'b1, 4'd5, 4'd6, 6'h00, 1'b0, 2'b01, 4'd5, 18'h000F0}; // AND r5=r5&r6
    vecs[3] = '{18'h0DC85, 1'b1, 4'd2, 4'd0, 6'h05, 1'b1, 2'b01, 4'd7, 18'd5};     // ANDI r7=r2&5
    vecs[4] = '{18'h12048, 1'b1, 4'd1, 4'd2, 6'h00, 1'b0, 2'b10, 4'd8, 18'h3FFFA}; // NAND r8
    vecs[5] = '{18'h14158, 1'b1, 4'd5, 4'd6, 6'h00, 1'b0, 2'b11, 4'd0, 18'h3000F}; // NOR r0
    vecs[6] = '{18'h1CC48, 1'b0, 4'd0, 4'd0, 6'h00, 1'b0, 2'b00, 4'd0, 18'd0};     // op 0111
    vecs[7] = '{18'h3FFFF, 1'b0, 4'd0, 4'd0, 6'h00, 1'b0, 2'b00, 4'd0, 18'd0};     // op 1111
    vecs[8] = '{18'h0E5B0, 1'b1, 4'd6, 4'd0, 6'h30, 1'b1, 2'b01, 4'd9, 18'h00FF0}; // ANDI r9=r6&-16

    rst         = 1'b1;
    instr       = 18'h0;
    instr_valid = 1'b0;
    wb_grant    = 1'b1;
    alu_corrupt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    check_counts();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Write-back stall: grant withheld for five WB cycles while the ALU output changes.
    wb_grant = 1'b0;
    c0 = commits;
    wait_ready();
    instr       = vecs[0].instr;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_we", 32'(rf_we), 32'd1);
      check("stall_waddr", 32'(rf_waddr), 32'd3);
      check("stall_wdata", 32'(rf_wdata), 32'd12);
      check("stall_no_done", 32'(done), 32'd0);
      check("stall_state", 32'(dbg_state), 32'd3);
      alu_corrupt = 1'b1;
      @(negedge clk);
    end
    wb_grant = 1'b1;
    #1;
    check("grant_done", 32'(done), 32'd1);
    check("grant_wdata", 32'(rf_wdata), 32'd12);
    exp_ret++;
    @(negedge clk);
    alu_corrupt = 1'b0;
    check("grant_idle", 32'(dbg_state), 32'd0);
    check("grant_ready", 32'(instr_ready), 32'd1);
    check("grant_one_commit", 32'(commits - c0), 32'd1);
    check_counts();

    // Reset while the instruction sits in EXEC: no write, counters cleared.
    c0 = commits;
    wait_ready();
    instr       = vecs[0].instr;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_exec", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    exp_ret = 0;
    exp_ill = 0;
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_ready", 32'(instr_ready), 32'd0);
    check("mid_rst_raddr1", 32'(rf_raddr1), 32'd0);
    check("mid_rst_raddr2", 32'(rf_raddr2), 32'd0);
    check("mid_rst_imm", 32'(alu_imm), 32'd0);
    check("mid_rst_mux1", 32'(alu_mux1_select), 32'd0);
    check("mid_rst_mux2", 32'(alu_mux2_select), 32'd0);
    check("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    check("mid_rst_wdata", 32'(rf_wdata), 32'd0);
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check_counts();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_write", 32'(commits - c0), 32'd0);
    run_vec(vecs[5]);

    // instr_valid held high: exactly one accept per 4-cycle instruction.
    wait_ready();
    acc_cnt     = 0;
    done_cnt    = 0;
    instr       = vecs[0].instr;
    instr_valid = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    exp_ret += 5;
    check("held_valid_accepts", 32'(acc_cnt), 32'd5);
    check("held_valid_dones", 32'(done_cnt), 32'd5);
    check("held_valid_idle", 32'(dbg_state), 32'd0);
    check_counts();

    // Counter wrap on the 3-bit copy: 7 -> 0.
    while (exp_ret < 7) run_vec(vecs[0]);
    check("w_retired_at_max", 32'(w_retired_count), 32'd7);
    run_vec(vecs[3]);
    check("w_retired_wrap", 32'(w_retired_count), 32'd0);
    check("retired_no_wrap", 32'(retired_count), 32'd8);
    while (exp_ill < 8) run_vec(vecs[6]);
    check("w_illegal_wrap", 32'(w_illegal_count), 32'd0);
    check("illegal_eight", 32'(illegal_count), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
